// File: rtl/round_scheduler_pkg.sv
// rtl/round_scheduler_pkg.sv - state encoding and default timing constants for round_scheduler
package round_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN      = 3'd2,
    S_LEVEL_UP = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [27:0] TIME_ON_INIT_DEF   = 28'd50_000_000;
  localparam logic [27:0] TIME_BTWN_INIT_DEF = 28'd25_000_000;
  localparam logic [27:0] TIME_STEP_DEF      = 28'd5_000_000;
  localparam logic [27:0] TIME_MIN_DEF       = 28'd5_000_000;
  localparam logic [5:0]  FLICKS_DEF         = 6'd10;
  localparam logic [2:0]  NUM_LEVELS_DEF     = 3'd5;

endpackage

// File: rtl/round_scheduler_time_stepper.sv
// rtl/round_scheduler_time_stepper.sv - time_stepper: subtract a fixed step from a 28-bit time, flooring at a minimum
module time_stepper #(
  parameter logic [27:0] TIME_STEP = 28'd5_000_000,
  parameter logic [27:0] TIME_MIN  = 28'd5_000_000
) (
  input  logic [27:0] t,
  output logic [27:0] t_next
);

  // 29-bit threshold so MIN+STEP cannot wrap for large parameter values
  localparam logic [28:0] THRESH = {1'b0, TIME_MIN} + {1'b0, TIME_STEP};

  assign t_next = ({1'b0, t} >= THRESH) ? (t - TIME_STEP) : TIME_MIN;

endmodule

// File: rtl/round_scheduler.sv
// rtl/round_scheduler.sv - whack-a-mole level sequencer driving light_controller timing
// Optional macro PAUSE_EN adds a pause input that freezes the RUN state.
module round_scheduler
  import round_scheduler_pkg::*;
#(
  parameter logic [27:0] TIME_ON_INIT     = TIME_ON_INIT_DEF,
  parameter logic [27:0] TIME_BTWN_INIT   = TIME_BTWN_INIT_DEF,
  parameter logic [27:0] TIME_STEP        = TIME_STEP_DEF,
  parameter logic [27:0] TIME_MIN         = TIME_MIN_DEF,
  parameter logic [5:0]  FLICKS_PER_LEVEL = FLICKS_DEF,
  parameter logic [2:0]  NUM_LEVELS       = NUM_LEVELS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        hit,
  input  logic [5:0]  flick_count,
`ifdef PAUSE_EN
  input  logic        pause,
`endif
  output logic [27:0] time_on,
  output logic [27:0] time_between,
  output logic        start,
  output logic        load_seed,
  output logic [2:0]  level,
  output logic [7:0]  score,
  output logic        game_over
);

  state_t      state, state_d;
  logic [5:0]  snapshot;
  logic [5:0]  done_flicks;
  logic        last_level;
  logic        pause_in;
  logic        paused;
  logic [27:0] time_on_step, time_btwn_step;

`ifdef PAUSE_EN
  assign pause_in = pause;
`else
  assign pause_in = 1'b0;
`endif

  assign paused      = (state == S_RUN) && pause_in;
  // modular 6-bit subtract absorbs the light counter wrapping 63->0
  assign done_flicks = flick_count - snapshot;
  assign last_level  = (level == (NUM_LEVELS - 3'd1));

  time_stepper #(.TIME_STEP(TIME_STEP), .TIME_MIN(TIME_MIN)) u_step_on (
    .t      (time_on),
    .t_next (time_on_step)
  );

  time_stepper #(.TIME_STEP(TIME_STEP), .TIME_MIN(TIME_MIN)) u_step_btwn (
    .t      (time_between),
    .t_next (time_btwn_step)
  );

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: if (go) state_d = S_LOAD;
      S_LOAD:         state_d = S_RUN;
      S_RUN: begin
        if (!paused && (done_flicks == FLICKS_PER_LEVEL))
          state_d = last_level ? S_DONE : S_LEVEL_UP;
      end
      S_LEVEL_UP:     state_d = S_RUN;
      default:        state_d = S_IDLE;
    endcase
  end

  // Outputs derive from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      time_on      <= TIME_ON_INIT;
      time_between <= TIME_BTWN_INIT;
      start        <= 1'b0;
      load_seed    <= 1'b0;
      level        <= 3'd0;
      score        <= 8'd0;
      game_over    <= 1'b0;
      snapshot     <= 6'd0;
    end else begin
      state     <= state_d;
      start     <= (state_d == S_RUN) && !pause_in;
      load_seed <= (state_d == S_LOAD);
      game_over <= (state_d == S_DONE);

      if (state == S_LOAD || state == S_LEVEL_UP)
        snapshot <= flick_count;

      if (state_d == S_LOAD) begin
        level        <= 3'd0;
        time_on      <= TIME_ON_INIT;
        time_between <= TIME_BTWN_INIT;
      end else if (state_d == S_LEVEL_UP) begin
        level        <= level + 3'd1;
        time_on      <= time_on_step;
        time_between <= time_btwn_step;
      end

      if (state_d == S_LOAD)
        score <= 8'd0;
      else if (hit && score != 8'hFF && ((state == S_RUN && !paused) || state == S_LEVEL_UP))
        score <= score + 8'd1;
    end
  end

endmodule

// File: tb/tb_round_scheduler.sv
// tb/tb_round_scheduler.sv - table/scoreboard bench for round_scheduler (define PAUSE_EN to test pause)
module tb_round_scheduler;

  typedef struct packed {
    logic        st;
    logic        ld;
    logic [2:0]  lvl;
    logic [7:0]  sc;
    logic        gov;
    logic [27:0] ton;
    logic [27:0] tb;
  } exp_t;

  typedef struct packed {
    logic       go;
    logic       hit;
    logic [5:0] flick;
    exp_t       e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0, hit = 1'b0;
  logic [5:0]  flick = 6'd0;
  logic        pause = 1'b0;
  logic [27:0] time_on, time_between;
  logic        start, load_seed, game_over;
  logic [2:0]  level;
  logic [7:0]  score;

  logic        go2 = 1'b0, hit2 = 1'b0, pause2 = 1'b0;
  logic [5:0]  flick2 = 6'd0;
  logic [27:0] time_on2, time_between2;
  logic        start2, load_seed2, game_over2;
  logic [2:0]  level2;
  logic [7:0]  score2;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  vec_t tbl[24];

  always #5 clk = ~clk;

  round_scheduler dut (
    .clk(clk), .reset(reset), .go(go), .hit(hit), .flick_count(flick),
`ifdef PAUSE_EN
    .pause(pause),
`endif
    .time_on(time_on), .time_between(time_between), .start(start),
    .load_seed(load_seed), .level(level), .score(score), .game_over(game_over)
  );

  round_scheduler #(.TIME_STEP(28'd10_000_000), .NUM_LEVELS(3'd7), .FLICKS_PER_LEVEL(6'd1)) dut2 (
    .clk(clk), .reset(reset), .go(go2), .hit(hit2), .flick_count(flick2),
`ifdef PAUSE_EN
    .pause(pause2),
`endif
    .time_on(time_on2), .time_between(time_between2), .start(start2),
    .load_seed(load_seed2), .level(level2), .score(score2), .game_over(game_over2)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk_e(logic st, logic ld, int lvl, int sc, logic gov, int ton_m, int tb_m);
    exp_t e;
    e.st  = st;
    e.ld  = ld;
    e.lvl = 3'(lvl);
    e.sc  = 8'(sc);
    e.gov = gov;
    e.ton = 28'(ton_m * 1_000_000);
    e.tb  = 28'(tb_m * 1_000_000);
    return e;
  endfunction

  function automatic vec_t mk(logic g, logic h, int f, logic st, logic ld, int lvl, int sc,
                              logic gov, int ton_m, int tb_m);
    vec_t v;
    v.go    = g;
    v.hit   = h;
    v.flick = 6'(f);
    v.e     = mk_e(st, ld, lvl, sc, gov, ton_m, tb_m);
    return v;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " start"},        32'(start),        32'(e.st));
      check({tag, " load_seed"},    32'(load_seed),    32'(e.ld));
      check({tag, " level"},        32'(level),        32'(e.lvl));
      check({tag, " score"},        32'(score),        32'(e.sc));
      check({tag, " game_over"},    32'(game_over),    32'(e.gov));
      check({tag, " time_on"},      32'(time_on),      32'(e.ton));
      check({tag, " time_between"}, 32'(time_between), 32'(e.tb));
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    go    = v.go;
    hit   = v.hit;
    flick = v.flick;
    exp_q.push_back(v.e);
    tick();
    compare_out(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    exp_q.push_back(mk_e(0, 0, 0, 0, 0, 50, 25));
    compare_out(tag);
  endtask

  int ton2_m[7] = '{50, 40, 30, 20, 10, 5, 5};
  int tb2_m[7]  = '{25, 15, 5, 5, 5, 5, 5};

  initial begin
    tbl[0]  = mk(1, 0,  0, 0, 1, 0, 0, 0, 50, 25);
    tbl[1]  = mk(0, 0,  0, 1, 0, 0, 0, 0, 50, 25);
    tbl[2]  = mk(0, 1,  1, 1, 0, 0, 1, 0, 50, 25);
    tbl[3]  = mk(0, 0,  5, 1, 0, 0, 1, 0, 50, 25);
    tbl[4]  = mk(0, 1,  9, 1, 0, 0, 2, 0, 50, 25);
    tbl[5]  = mk(0, 0, 10, 0, 0, 1, 2, 0, 45, 20);
    tbl[6]  = mk(0, 1, 10, 1, 0, 1, 3, 0, 45, 20);
    tbl[7]  = mk(0, 0, 19, 1, 0, 1, 3, 0, 45, 20);
    tbl[8]  = mk(0, 1, 20, 0, 0, 2, 4, 0, 40, 15);
    tbl[9]  = mk(0, 0, 20, 1, 0, 2, 4, 0, 40, 15);
    tbl[10] = mk(0, 0, 30, 0, 0, 3, 4, 0, 35, 10);
    tbl[11] = mk(0, 0, 30, 1, 0, 3, 4, 0, 35, 10);
    tbl[12] = mk(0, 0, 40, 0, 0, 4, 4, 0, 30,  5);
    tbl[13] = mk(0, 0, 40, 1, 0, 4, 4, 0, 30,  5);
    tbl[14] = mk(1, 0, 49, 1, 0, 4, 4, 0, 30,  5);
    tbl[15] = mk(0, 1, 50, 0, 0, 4, 5, 1, 30,  5);
    tbl[16] = mk(0, 1, 55, 0, 0, 4, 5, 1, 30,  5);
    tbl[17] = mk(1, 0, 55, 0, 1, 0, 0, 0, 50, 25);
    tbl[18] = mk(0, 0, 60, 1, 0, 0, 0, 0, 50, 25);
    tbl[19] = mk(0, 0, 63, 1, 0, 0, 0, 0, 50, 25);
    tbl[20] = mk(0, 0,  0, 1, 0, 0, 0, 0, 50, 25);
    tbl[21] = mk(0, 0,  5, 1, 0, 0, 0, 0, 50, 25);
    tbl[22] = mk(0, 0,  6, 0, 0, 1, 0, 0, 45, 20);
    tbl[23] = mk(0, 0,  6, 1, 0, 1, 0, 0, 45, 20);

    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;

    for (int i = 0; i < 24; i++)
      run_vec(tbl[i], $sformatf("row%0d", i));

    for (int i = 0; i < 300; i++)
      run_vec(mk(0, 1, 6, 1, 0, 1, (i + 1 > 255) ? 255 : i + 1, 0, 45, 20),
              $sformatf("hit%0d", i));

    run_vec(mk(0, 0, 16, 0, 0, 2, 255, 0, 40, 15), "end_a");
    run_vec(mk(0, 0, 16, 1, 0, 2, 255, 0, 40, 15), "end_b");
    run_vec(mk(0, 0, 26, 0, 0, 3, 255, 0, 35, 10), "end_c");
    run_vec(mk(0, 0, 26, 1, 0, 3, 255, 0, 35, 10), "end_d");
    run_vec(mk(0, 0, 36, 0, 0, 4, 255, 0, 30,  5), "end_e");
    run_vec(mk(0, 0, 36, 1, 0, 4, 255, 0, 30,  5), "end_f");
    run_vec(mk(0, 1, 46, 0, 0, 4, 255, 1, 30,  5), "end_done");

    run_vec(mk(1, 0, 46, 0, 1, 0, 0, 0, 50, 25), "restart_load");
    run_vec(mk(0, 0, 46, 1, 0, 0, 0, 0, 50, 25), "restart_run");
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    tick();
    reset = 1'b0;

`ifdef PAUSE_EN
    run_vec(mk(1, 0, 0, 0, 1, 0, 0, 0, 50, 25), "p_load");
    run_vec(mk(0, 0, 0, 1, 0, 0, 0, 0, 50, 25), "p_run");
    pause = 1'b1;
    run_vec(mk(0, 1, 10, 0, 0, 0, 0, 0, 50, 25), "p_hold_a");
    run_vec(mk(0, 1, 10, 0, 0, 0, 0, 0, 50, 25), "p_hold_b");
    pause = 1'b0;
    run_vec(mk(0, 0, 10, 0, 0, 1, 0, 0, 45, 20), "p_levelup");
`endif

    go2 = 1'b1;
    tick();
    check("floor load_seed", 32'(load_seed2), 32'd1);
    go2 = 1'b0;
    flick2 = 6'd0;
    tick();
    check("floor start", 32'(start2), 32'd1);
    for (int l = 1; l < 7; l++) begin
      flick2 = 6'(l);
      tick();
      check($sformatf("floor lvl%0d level", l), 32'(level2), 32'(l));
      check($sformatf("floor lvl%0d start", l), 32'(start2), 32'd0);
      check($sformatf("floor lvl%0d time_on", l), 32'(time_on2), 32'(ton2_m[l] * 1_000_000));
      check($sformatf("floor lvl%0d time_between", l), 32'(time_between2), 32'(tb2_m[l] * 1_000_000));
      tick();
    end
    flick2 = 6'd7;
    tick();
    check("floor game_over", 32'(game_over2), 32'd1);
    check("floor time_on held", 32'(time_on2), 32'd5_000_000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
